// File: rtl/lsu_pkg.sv
// Shared width codes, FSM state type, latched-request struct and the illegal-encoding check for load_store_unit.
// The optional misalignment trap (macro LSU_MISALIGN_TRAP_EN) is applied in load_store_unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LDRET = 3'd2,
        ST_WR    = 3'd3,
        ST_FLT   = 3'd4
    } lsu_state_e;

    // A legal request is exactly one of load/store, so is_load alone encodes the type.
    typedef struct packed {
        logic        is_load;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } lsu_req_t;

    function automatic logic lsu_is_illegal(input logic is_load, input logic is_store,
                                            input logic [2:0] funct3);
        logic bad_s;
        if (is_load == is_store) begin
            bad_s = 1'b1;
        end else if (is_load) begin
            bad_s = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else begin
            bad_s = (funct3 > F3_W);
        end
        return bad_s;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Lane extraction and sign/zero extension of a memory word, plus the mask of the
// addressed lane so the store-merge path can reuse the same lane selection.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result,
    output logic [31:0] lane_mask
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] byte_mask_s;
    logic [31:0] half_mask_s;

    // Select the addressed byte and half; a half ignores offset[0].
    always_comb begin
        byte_s      = 8'h00;
        byte_mask_s = 32'h0000_0000;
        case (offset)
            2'b00:   begin byte_s = mem_word[7:0];   byte_mask_s = 32'h0000_00FF; end
            2'b01:   begin byte_s = mem_word[15:8];  byte_mask_s = 32'h0000_FF00; end
            2'b10:   begin byte_s = mem_word[23:16]; byte_mask_s = 32'h00FF_0000; end
            2'b11:   begin byte_s = mem_word[31:24]; byte_mask_s = 32'hFF00_0000; end
            default: begin byte_s = 8'h00;           byte_mask_s = 32'h0000_0000; end
        endcase
        if (offset[1]) begin
            half_s      = mem_word[31:16];
            half_mask_s = 32'hFFFF_0000;
        end else begin
            half_s      = mem_word[15:0];
            half_mask_s = 32'h0000_FFFF;
        end
    end

    // Extend per width code; unknown codes produce zero and an empty mask.
    always_comb begin
        result    = 32'h0000_0000;
        lane_mask = 32'h0000_0000;
        case (funct3)
            F3_B:    begin result = {{24{byte_s[7]}}, byte_s};  lane_mask = byte_mask_s; end
            F3_BU:   begin result = {24'h00_0000, byte_s};      lane_mask = byte_mask_s; end
            F3_H:    begin result = {{16{half_s[15]}}, half_s}; lane_mask = half_mask_s; end
            F3_HU:   begin result = {16'h0000, half_s};         lane_mask = half_mask_s; end
            F3_W:    begin result = mem_word;                   lane_mask = 32'hFFFF_FFFF; end
            default: begin result = 32'h0000_0000;              lane_mask = 32'h0000_0000; end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage driving Datamemory: word-indexed accesses, read-modify-write sub-word stores,
// aligned/extended loads. Defining LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_load,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [4:0]      rsp_rd,
    output logic            rsp_fault,
    output logic [XLEN-1:0] mem_mar,
    output logic [XLEN-1:0] mem_mdr,
    output logic            mem_isld,
    output logic            mem_isst,
    input  logic [XLEN-1:0] mem_ldresult
);

    lsu_state_e  state_r, state_next_s;
    lsu_req_t    req_r;
    logic        accept_s, illegal_s, misalign_s;
    logic        isld_s, isst_s;
    logic [31:0] mar_s, mdr_s, word_idx_s;
    logic [31:0] align_result_s, lane_mask_s, rep_s, merged_s;
    logic        rsp_valid_r, rsp_fault_r;
    logic [31:0] rsp_rdata_r;
    logic [4:0]  rsp_rd_r;

    assign req_ready  = (state_r == ST_IDLE);
    assign accept_s   = req_valid && req_ready;
    assign word_idx_s = {2'b00, req_r.addr[31:2]};

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif
    assign illegal_s = lsu_is_illegal(req_is_load, req_is_store, req_funct3) || misalign_s;

    lsu_load_align u_align (
        .mem_word  (mem_ldresult),
        .offset    (req_r.addr[1:0]),
        .funct3    (req_r.funct3),
        .result    (align_result_s),
        .lane_mask (lane_mask_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // Next-state logic: SW writes directly, SB/SH read first, illegal requests take the fault path.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s)                 state_next_s = ST_IDLE;
                else if (illegal_s)            state_next_s = ST_FLT;
                else if (req_is_load)          state_next_s = ST_RD;
                else if (req_funct3 == F3_W)   state_next_s = ST_WR;
                else                           state_next_s = ST_RD;
            end
            ST_RD: begin
                if (req_r.is_load) state_next_s = ST_LDRET;
                else               state_next_s = ST_WR;
            end
            ST_LDRET: state_next_s = ST_IDLE;
            ST_WR:    state_next_s = ST_IDLE;
            ST_FLT:   state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Request latch, captured on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_r <= '0;
        end else if (accept_s) begin
            req_r.is_load <= req_is_load;
            req_r.funct3  <= req_funct3;
            req_r.addr    <= req_addr;
            req_r.wdata   <= req_wdata;
            req_r.rd      <= req_rd;
        end
    end

    // Sub-word store merge: replicate the store lane and splice it into the word read in RD.
    always_comb begin
        if (req_r.funct3 == F3_B) rep_s = {4{req_r.wdata[7:0]}};
        else                      rep_s = {2{req_r.wdata[15:0]}};
        merged_s = (mem_ldresult & ~lane_mask_s) | (rep_s & lane_mask_s);
    end

    // Memory strobes and address/data; strobes are suppressed while rst is high.
    always_comb begin
        isld_s = 1'b0;
        isst_s = 1'b0;
        mar_s  = 32'h0000_0000;
        mdr_s  = 32'h0000_0000;
        case (state_r)
            ST_RD: begin
                isld_s = ~rst;
                mar_s  = word_idx_s;
            end
            ST_WR: begin
                isst_s = ~rst;
                mar_s  = word_idx_s;
                mdr_s  = (req_r.funct3 == F3_W) ? req_r.wdata : merged_s;
            end
            default: begin
                isld_s = 1'b0;
                isst_s = 1'b0;
            end
        endcase
    end

    assign mem_isld = isld_s;
    assign mem_isst = isst_s;
    assign mem_mar  = mar_s;
    assign mem_mdr  = mdr_s;

    // Response registers: one-cycle pulse on leaving LDRET, WR or FLT.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_fault_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_rd_r    <= 5'd0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_LDRET: begin
                    rsp_valid_r <= 1'b1;
                    rsp_fault_r <= 1'b0;
                    rsp_rdata_r <= align_result_s;
                    rsp_rd_r    <= req_r.rd;
                end
                ST_WR: begin
                    rsp_valid_r <= 1'b1;
                    rsp_fault_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_rd_r    <= req_r.rd;
                end
                ST_FLT: begin
                    rsp_valid_r <= 1'b1;
                    rsp_fault_r <= 1'b1;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_rd_r    <= req_r.rd;
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_fault = rsp_fault_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_rd    = rsp_rd_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural Datamemory (16 words, decodes mar[3:0]).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_is_load = 1'b0, req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata, mem_mar, mem_mdr, mem_ldresult;
    logic [4:0]  rsp_rd;
    logic        mem_isld, mem_isst;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          isld_cnt = 0, isst_cnt = 0;
    logic [31:0] exp_mar = 32'h0;
    logic [31:0] dmem [16];

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_load(req_is_load), .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_fault(rsp_fault),
        .mem_mar(mem_mar), .mem_mdr(mem_mdr), .mem_isld(mem_isld), .mem_isst(mem_isst),
        .mem_ldresult(mem_ldresult)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datamemory model: registered read on isld, whole-word write on isst.
    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        mem_ldresult = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_isld) mem_ldresult <= dmem[mem_mar[3:0]];
        if (mem_isst) dmem[mem_mar[3:0]] <= mem_mdr;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: strobe sanity and scoreboard comparison of every response.
    always @(negedge clk) begin
        if (mem_isld) isld_cnt++;
        if (mem_isst) isst_cnt++;
        if (mem_isld || mem_isst) begin
            chk("strobe_excl", {31'b0, mem_isld & mem_isst}, 32'h0);
            chk("mem_mar", mem_mar, exp_mar);
        end
        if (rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rd %0d rdata %h, required no response", rsp_rd, rsp_rdata);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_rd", {27'b0, rsp_rd}, {27'b0, e.rd});
                chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
                chk("rsp_latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] erdata, input logic efault, input int elat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", {31'b0, req_ready}, 32'h1);
            return;
        end
        exp_mar      = {2'b00, a[31:2]};
        req_valid    = 1'b1;
        req_is_load  = ld;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        @(posedge clk);
        #1;
        e.rdata = erdata; e.rd = rd; e.fault = efault; e.lat = elat; e.acc = cyc;
        q.push_back(e);
        req_valid = 1'b0;
        @(negedge clk);
        chk("req_ready_busy", {31'b0, req_ready}, 32'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("rsp_timeout", q.size(), 32'h0);
            q.delete();
        end
    endtask

    task automatic fault_case(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] a);
        drain();
        isld_cnt = 0;
        isst_cnt = 0;
        issue(ld, st, f3, a, 32'h5A5A_5A5A, 5'd30, 32'h0, 1'b1, 2);
        drain();
        chk({nm, "_no_strobes"}, isld_cnt + isst_cnt, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset_rsp_fault", {31'b0, rsp_fault}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_rd", {27'b0, rsp_rd}, 32'h0);
        chk("reset_mem_mar", mem_mar, 32'h0);
        chk("reset_mem_mdr", mem_mdr, 32'h0);
        chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
        chk("reset_strobes", {30'b0, mem_isld, mem_isst}, 32'h0);

        // Word store then load, back to back.
        issue(1'b0, 1'b1, 3'b010, 32'h4, 32'hCAFE_BABE, 5'd1, 32'h0, 1'b0, 2);
        issue(1'b1, 1'b0, 3'b010, 32'h4, 32'h0,         5'd2, 32'hCAFE_BABE, 1'b0, 3);
        // Byte store via read-modify-write, then loads of every width.
        issue(1'b0, 1'b1, 3'b010, 32'h8, 32'h1122_3344, 5'd3, 32'h0, 1'b0, 2);
        issue(1'b0, 1'b1, 3'b000, 32'h9, 32'h0000_00AA, 5'd4, 32'h0, 1'b0, 3);
        issue(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd5, 32'h1122_AA44, 1'b0, 3);
        issue(1'b1, 1'b0, 3'b000, 32'h9, 32'h0, 5'd6, 32'hFFFF_FFAA, 1'b0, 3);
        issue(1'b1, 1'b0, 3'b100, 32'h9, 32'h0, 5'd7, 32'h0000_00AA, 1'b0, 3);
        // Halfword store on the upper half, then loads.
        issue(1'b0, 1'b1, 3'b001, 32'hA, 32'h0000_8001, 5'd8, 32'h0, 1'b0, 3);
        issue(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd9,  32'h8001_AA44, 1'b0, 3);
        issue(1'b1, 1'b0, 3'b001, 32'hA, 32'h0, 5'd10, 32'hFFFF_8001, 1'b0, 3);
        issue(1'b1, 1'b0, 3'b101, 32'hA, 32'h0, 5'd11, 32'h0000_8001, 1'b0, 3);
        // Address aliasing: byte address 0x44 decodes to the same word as 0x4.
        issue(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 5'd12, 32'hCAFE_BABE, 1'b0, 3);

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        fault_case("misaligned_lw", 1'b1, 1'b0, 3'b010, 32'h6);
`else
        issue(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd13, 32'hCAFE_BABE, 1'b0, 3);
`endif

        // Illegal encodings.
        fault_case("both_types", 1'b1, 1'b1, 3'b010, 32'h4);
        fault_case("no_type",    1'b0, 1'b0, 3'b010, 32'h4);
        fault_case("ld_f3_011",  1'b1, 1'b0, 3'b011, 32'h4);
        fault_case("st_f3_011",  1'b0, 1'b1, 3'b011, 32'h4);
        issue(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 5'd14, 32'hCAFE_BABE, 1'b0, 3);
        drain();

        // Reset during the WR cycle of an SB: no write, no response.
        @(negedge clk);
        exp_mar      = 32'h2;
        req_valid    = 1'b1;
        req_is_load  = 1'b0;
        req_is_store = 1'b1;
        req_funct3   = 3'b000;
        req_addr     = 32'h9;
        req_wdata    = 32'h0000_0055;
        req_rd       = 5'd15;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_isst_gated", {31'b0, mem_isst}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rd", {27'b0, rsp_rd}, 32'h0);
        chk("rst_mem_mar", mem_mar, 32'h0);
        chk("rst_mem_mdr", mem_mdr, 32'h0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        issue(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd16, 32'h8001_AA44, 1'b0, 3);
        drain();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion before 100000 time units");
        $fatal(1, "watchdog");
    end

endmodule
